ws2812: RTL and testbench



---
 rtl/ws2812_pkg.sv | 13 +
 rtl/ws2812_bit_timer.sv | 27 ++
 rtl/ws2812.sv | 95 +++++++++
 tb/tb_ws2812.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/ws2812_pkg.sv
// ws2812_pkg: shared state encoding, default timing and colour-word layout for the ws2812 driver.
package ws2812_pkg;
    typedef enum logic {LATCH = 1'b0, DATA = 1'b1} state_e;
    localparam int WORD_W = 24;
    localparam int DEF_LEDS = 2;
    localparam int DEF_T_BIT = 15;
    localparam int DEF_T0H = 4;
    localparam int DEF_T1H = 9;
    localparam int DEF_T_RESET = 700;
    function automatic logic [WORD_W-1:0] grb_word(input logic [7:0] r, input logic [7:0] g, input logic [7:0] b);
        return {g, r, b};
    endfunction
endpackage

// File: rtl/ws2812_bit_timer.sv
// ws2812_bit_timer: times one NRZ bit slot; runs while start is high, high phase length follows bit_val.
module ws2812_bit_timer
    import ws2812_pkg::*;
#(
    parameter int t_bit = DEF_T_BIT,
    parameter int t0h = DEF_T0H,
    parameter int t1h = DEF_T1H
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic bit_val,
    output logic high,
    output logic bit_done
);
    localparam int CW = $clog2(t_bit);
    logic [CW-1:0] cnt_q, cnt_d;
    always_comb begin
        bit_done = start && cnt_q == CW'(t_bit - 1);
        high = start && cnt_q < (bit_val ? CW'(t1h) : CW'(t0h));
        cnt_d = (start && !bit_done) ? cnt_q + 1'b1 : '0;
    end
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else cnt_q <= cnt_d;
    end
endmodule

// File: rtl/ws2812.sv
// ws2812: repeats one GRB word per LED on a single-wire NRZ line, then a low latch gap.
// Define WS2812_INVERT_EN to drive the inverted waveform for inverting level shifters.
module ws2812
    import ws2812_pkg::*;
#(
    parameter int leds = DEF_LEDS,
    parameter int t_bit = DEF_T_BIT,
    parameter int t0h = DEF_T0H,
    parameter int t1h = DEF_T1H,
    parameter int t_reset = DEF_T_RESET
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] red,
    input  logic [7:0] green,
    input  logic [7:0] blue,
    output logic       data
);
    localparam int LCW = (leds > 1) ? $clog2(leds) : 1;
    localparam int RCW = $clog2(t_reset);
    localparam logic [LCW-1:0] LED_LAST = LCW'(leds - 1);
    localparam logic [4:0] BIT_TOP = 5'(WORD_W - 1);
`ifdef WS2812_INVERT_EN
    localparam logic IDLE = 1'b1;
`else
    localparam logic IDLE = 1'b0;
`endif
    generate
        if (!(t0h >= 1 && t0h < t1h && t1h < t_bit)) begin : g_bad_timing
            $error("ws2812: timing requires 1 <= t0h < t1h < t_bit");
        end
    endgenerate
    state_e state, state_d;
    logic [LCW-1:0] led_counter, led_counter_d;
    logic [4:0] bit_idx_q, bit_idx_d;
    logic [WORD_W-1:0] shift_q, shift_d;
    logic [RCW-1:0] gap_q, gap_d;
    logic data_q, data_d, high, bit_done;
    ws2812_bit_timer #(.t_bit(t_bit), .t0h(t0h), .t1h(t1h)) u_bit_timer (
        .clk(clk),
        .reset(reset),
        .start(state == DATA),
        .bit_val(shift_q[WORD_W-1]),
        .high(high),
        .bit_done(bit_done)
    );
    always_comb begin
        state_d = state;
        led_counter_d = led_counter;
        bit_idx_d = bit_idx_q;
        shift_d = shift_q;
        gap_d = '0;
        data_d = IDLE ^ (state == DATA && high);
        if (state == LATCH) begin
            gap_d = gap_q + 1'b1;
            if (gap_q == RCW'(t_reset - 1)) begin
                state_d = DATA;
                gap_d = '0;
                bit_idx_d = BIT_TOP;
                led_counter_d = LED_LAST;
                shift_d = grb_word(red, green, blue);
            end
        end else if (bit_done) begin
            // colour inputs are only sampled at word boundaries so each LED gets a coherent word
            if (bit_idx_q != 0) begin
                bit_idx_d = bit_idx_q - 1'b1;
                shift_d = shift_q << 1;
            end else if (led_counter != 0) begin
                led_counter_d = led_counter - 1'b1;
                bit_idx_d = BIT_TOP;
                shift_d = grb_word(red, green, blue);
            end else begin
                state_d = LATCH;
            end
        end
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= LATCH;
            led_counter <= LED_LAST;
            bit_idx_q <= BIT_TOP;
            shift_q <= '0;
            gap_q <= '0;
            data_q <= IDLE;
        end else begin
            state <= state_d;
            led_counter <= led_counter_d;
            bit_idx_q <= bit_idx_d;
            shift_q <= shift_d;
            gap_q <= gap_d;
            data_q <= data_d;
        end
    end
    assign data = data_q;
endmodule

// File: tb/tb_ws2812.sv
// tb_ws2812: scoreboard bench decoding the serial waveform of a 2-LED and a 1-LED ws2812 instance.
module tb_ws2812;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [7:0] red = 8'd100, green = 8'd0, blue = 8'd255;
    logic [7:0] red1 = 8'h00, green1 = 8'h80, blue1 = 8'h01;
    logic data, data1;
    int n_chk = 0, n_pass = 0;
    bit q[$];
    logic [23:0] q1[$];

    always #5 clk = ~clk;

    ws2812 dut (.clk(clk), .reset(reset), .red(red), .green(green), .blue(blue), .data(data));
    ws2812 #(.leds(1)) dut1 (.clk(clk), .reset(reset), .red(red1), .green(green1), .blue(blue1), .data(data1));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic push_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) q.push_back(w[i]);
    endtask

    task automatic wait_state(input logic v, input string tag);
        int n = 0;
        while (dut.state !== v && n < 3000) begin
            tick();
            n++;
        end
        chk(tag, dut.state, v);
    endtask

    // waveform decoder for the 2-LED instance
    int cyc = 0, h = 0, last_rise = 0, bits = 0;
    logic pd = 1'b0, ps = 1'b0;
    bit have_last = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            h = 0;
            bits = 0;
            have_last = 1'b0;
            pd = data;
            ps = 1'b0;
        end else begin
            if (data && !pd) begin
                if (have_last && bits == 0) chk("frame_gap", cyc - last_rise, 715);
                else if (have_last) chk("bit_period", cyc - last_rise, 15);
                last_rise = cyc;
                have_last = 1'b1;
                h = 0;
            end
            if (data) h++;
            if (!data && pd) begin
                bits++;
                chk("sb_has_entry", q.size() != 0, 1);
                if (q.size() != 0) chk("bit", h == 9 ? 1 : h == 4 ? 0 : 2, q.pop_front());
            end
            if (ps && !dut.state) begin
                chk("frame_bits", bits, 48);
                bits = 0;
            end
            pd = data;
            ps = dut.state;
        end
    end

    // waveform decoder for the 1-LED instance
    int h1 = 0, b1 = 0, dc1 = 0, hbad1 = 0, lcbad = 0;
    logic pd1 = 1'b0, ps1 = 1'b0;
    logic [23:0] w1 = '0;
    always @(negedge clk) begin
        if (reset) begin
            h1 = 0;
            b1 = 0;
            dc1 = 0;
            pd1 = data1;
            ps1 = 1'b0;
        end else begin
            if (data1) h1++;
            if (!data1 && pd1) begin
                w1 = {w1[22:0], h1 == 9};
                if (h1 != 4 && h1 != 9) hbad1++;
                b1++;
                h1 = 0;
            end
            if (dut1.state) dc1++;
            if (ps1 && !dut1.state) begin
                chk("l1_frame_bits", b1, 24);
                chk("l1_data_cycles", dc1, 360);
                if (q1.size() != 0) chk("l1_word", w1, q1.pop_front());
                b1 = 0;
                dc1 = 0;
            end
            if (dut1.led_counter != 0) lcbad++;
            pd1 = data1;
            ps1 = dut1.state;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n, s_at, c;
        repeat (4) push_word(24'h0064FF);
        repeat (2) q1.push_back(24'h800001);
        #17;
        chk("rst_state", dut.state, 0);
        chk("rst_led_counter", dut.led_counter, 1);
        chk("rst_data", data, 0);
        chk("rst_data_l1", data1, 0);
        #3 reset = 1'b0;
        n = 0;
        s_at = 0;
        while (!data && n < 2000) begin
            tick();
            n++;
            if (dut.state && s_at == 0) s_at = n;
        end
        chk("first_latch_exit", s_at, 700);
        chk("first_rise", n, 701);
        repeat (358) tick();
        chk("led0_last_cycle", dut.led_counter, 1);
        tick();
        chk("led1_first_cycle", dut.led_counter, 0);
        repeat (359) tick();
        chk("frame_last_cycle", dut.state, 1);
        tick();
        chk("latch_entry", dut.state, 0);
        c = 0;
        while (!dut.state && c < 2000) begin
            c++;
            tick();
        end
        chk("latch_len", c, 700);
        push_word(24'h0064FF);
        push_word(24'h006400);
        wait_state(1'b0, "frame2_end");
        wait_state(1'b1, "frame3_start");
        repeat (50) tick();
        blue = 8'h00;
        chk("mid_word_led", dut.led_counter, 1);
        push_word(24'h006400);
        push_word(24'h006400);
        wait_state(1'b0, "frame3_end");
        wait_state(1'b1, "frame4_start");
        repeat (100) tick();
        n = 0;
        while (!data && n < 20) begin
            tick();
            n++;
        end
        chk("abort_in_high", data, 1);
        reset = 1'b1;
        q.delete();
        tick();
        chk("abort_data", data, 0);
        chk("abort_state", dut.state, 0);
        chk("abort_led_counter", dut.led_counter, 1);
        repeat (2) tick();
        push_word(24'h006400);
        push_word(24'h006400);
        reset = 1'b0;
        n = 0;
        s_at = 0;
        while (!data && n < 2000) begin
            tick();
            n++;
            if (dut.state && s_at == 0) s_at = n;
        end
        chk("rst_latch_exit", s_at, 700);
        chk("rst_rise", n, 701);
        wait_state(1'b0, "frame5_end");
        repeat (2) tick();
        chk("sb_drained", q.size(), 0);
        chk("l1_sb_drained", q1.size(), 0);
        chk("l1_led_counter_nonzero", lcbad, 0);
        chk("l1_bad_high_len", hbad1, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
